// File: rtl/edge_detector_multi.sv
// Multi-channel synchronised, debounced edge detector with sticky event status.
// Optional overrun flags are built only when EDGE_DET_OVERRUN_EN is defined.
module edge_detector_multi #(
  parameter int   CHANNELS     = 8,
  parameter int   SYNC_STAGES  = 2,
  parameter int   FILTER_DEPTH = 4,
  parameter logic RESET_VALUE  = 1'b0
) (
  input  logic                CLK_I,
  input  logic                RST_ASYNC_I,
  input  logic [CHANNELS-1:0] SIG_I,
  input  logic [CHANNELS-1:0] REDGE_EN_I,
  input  logic [CHANNELS-1:0] FEDGE_EN_I,
  input  logic                CLR_I,
  input  logic [CHANNELS-1:0] CLR_MASK_I,
  output logic [CHANNELS-1:0] SIG_LEVEL_O,
  output logic [CHANNELS-1:0] SIG_REDGE_O,
  output logic [CHANNELS-1:0] SIG_FEDGE_O,
  output logic [CHANNELS-1:0] EVT_STATUS_O,
  output logic [CHANNELS-1:0] EVT_OVR_O,
  output logic                IRQ_O
);

  localparam int CW = $clog2(FILTER_DEPTH + 1);
  localparam logic [CHANNELS-1:0] RST_LVL = {CHANNELS{RESET_VALUE}};
  localparam logic [CW-1:0] LAST = CW'(FILTER_DEPTH - 1);

  logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
  logic [CW-1:0]       r_cnt  [CHANNELS];
  logic [CHANNELS-1:0] r_level;
  logic [CHANNELS-1:0] r_redge;
  logic [CHANNELS-1:0] r_fedge;
  logic [CHANNELS-1:0] r_status;
  logic                r_irq;

  logic [CHANNELS-1:0] w_samp;
  logic [CHANNELS-1:0] w_diff;
  logic [CHANNELS-1:0] w_hit;
  logic [CHANNELS-1:0] w_set;
  logic [CHANNELS-1:0] w_clr;
  logic [CHANNELS-1:0] w_status_nxt;

  always_ff @(posedge CLK_I or posedge RST_ASYNC_I) begin
    if (RST_ASYNC_I) begin
      for (int s = 0; s < SYNC_STAGES; s++)
        r_sync[s] <= RST_LVL;
    end else begin
      r_sync[0] <= SIG_I;
      for (int s = 1; s < SYNC_STAGES; s++)
        r_sync[s] <= r_sync[s-1];
    end
  end

  assign w_samp = r_sync[SYNC_STAGES-1];
  assign w_diff = w_samp ^ r_level;

  // A channel toggles on the sample that would bring its count to FILTER_DEPTH
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < CHANNELS; i++)
      w_hit[i] = w_diff[i] && (r_cnt[i] == LAST);
  end

  always_ff @(posedge CLK_I or posedge RST_ASYNC_I) begin
    if (RST_ASYNC_I) begin
      for (int i = 0; i < CHANNELS; i++)
        r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!w_diff[i] || w_hit[i])
          r_cnt[i] <= '0;
        else
          r_cnt[i] <= r_cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK_I or posedge RST_ASYNC_I) begin
    if (RST_ASYNC_I) begin
      r_level <= RST_LVL;
      r_redge <= '0;
      r_fedge <= '0;
    end else begin
      r_level <= r_level ^ w_hit;
      r_redge <= w_hit & ~r_level;
      r_fedge <= w_hit & r_level;
    end
  end

  assign w_set = (r_redge & REDGE_EN_I) | (r_fedge & FEDGE_EN_I);
  assign w_clr = {CHANNELS{CLR_I}} & CLR_MASK_I;
  // Set is OR-ed after the clear so a same-cycle event is never lost
  assign w_status_nxt = (r_status & ~w_clr) | w_set;

  always_ff @(posedge CLK_I or posedge RST_ASYNC_I) begin
    if (RST_ASYNC_I) begin
      r_status <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_status <= w_status_nxt;
      r_irq    <= |w_status_nxt;
    end
  end

`ifdef EDGE_DET_OVERRUN_EN
  logic [CHANNELS-1:0] r_ovr;

  always_ff @(posedge CLK_I or posedge RST_ASYNC_I) begin
    if (RST_ASYNC_I)
      r_ovr <= '0;
    else
      r_ovr <= (r_ovr & ~w_clr) | (w_set & r_status & ~w_clr);
  end

  assign EVT_OVR_O = r_ovr;
`else
  assign EVT_OVR_O = '0;
`endif

  assign SIG_LEVEL_O  = r_level;
  assign SIG_REDGE_O  = r_redge;
  assign SIG_FEDGE_O  = r_fedge;
  assign EVT_STATUS_O = r_status;
  assign IRQ_O        = r_irq;

endmodule

// File: tb/tb_edge_detector_multi.sv
// Directed bench for edge_detector_multi at default parameters.
// Expected values are hand-derived from the edge/latency rules.
module tb_edge_detector_multi;

  logic       clk;
  logic       rst;
  logic [7:0] sig;
  logic [7:0] ren;
  logic [7:0] fen;
  logic       clr;
  logic [7:0] cmask;
  logic [7:0] level;
  logic [7:0] redge;
  logic [7:0] fedge;
  logic [7:0] status;
  logic [7:0] ovr;
  logic       irq;

  int n_chk;
  int n_err;

`ifdef EDGE_DET_OVERRUN_EN
  localparam logic [7:0] OVR_EXP = 8'h04;
`else
  localparam logic [7:0] OVR_EXP = 8'h00;
`endif

  edge_detector_multi dut (
    .CLK_I       (clk),
    .RST_ASYNC_I (rst),
    .SIG_I       (sig),
    .REDGE_EN_I  (ren),
    .FEDGE_EN_I  (fen),
    .CLR_I       (clr),
    .CLR_MASK_I  (cmask),
    .SIG_LEVEL_O (level),
    .SIG_REDGE_O (redge),
    .SIG_FEDGE_O (fedge),
    .EVT_STATUS_O(status),
    .EVT_OVR_O   (ovr),
    .IRQ_O       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] acc;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst   = 1'b1;
    sig   = '0;
    ren   = '0;
    fen   = '0;
    clr   = 1'b0;
    cmask = '0;

    #2;
    check("rst_level",  level,  8'h00);
    check("rst_redge",  redge,  8'h00);
    check("rst_status", status, 8'h00);
    check("rst_ovr",    ovr,    8'h00);
    check("rst_irq",    8'(irq), 8'h00);

    #10 rst = 1'b0;
    step(2);

    // ch0 rise: update after 6 edges counting the first sampling edge
    ren    = 8'h01;
    sig[0] = 1'b1;
    step(5);
    check("lat_level_early", level, 8'h00);
    check("lat_redge_early", redge, 8'h00);
    step(1);
    check("lat_level", level,  8'h01);
    check("lat_redge", redge,  8'h01);
    check("lat_stat0", status, 8'h00);
    step(1);
    check("pulse_1cyc", redge,   8'h00);
    check("stat_set",   status,  8'h01);
    check("irq_set",    8'(irq), 8'h01);
    clr   = 1'b1;
    cmask = 8'h01;
    step(1);
    check("stat_clr", status,  8'h00);
    check("irq_clr",  8'(irq), 8'h00);
    clr   = 1'b0;
    cmask = 8'h00;

    // 3-cycle glitch on ch3 must be rejected
    ren    = 8'hFF;
    sig[3] = 1'b1;
    step(3);
    sig[3] = 1'b0;
    acc    = '0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      acc = acc | redge;
    end
    check("glitch_redge",  acc,    8'h00);
    check("glitch_level",  level,  8'h01);
    check("glitch_status", status, 8'h00);

    // ch0 fall with only rising enabled, then rise coincident with clear
    ren    = 8'h01;
    fen    = 8'h00;
    sig[0] = 1'b0;
    step(8);
    check("fall_level",  level,  8'h00);
    check("fall_status", status, 8'h00);
    sig[0] = 1'b1;
    step(6);
    check("coin_redge", redge, 8'h01);
    clr   = 1'b1;
    cmask = 8'h01;
    step(1);
    check("coin_status", status, 8'h01);
    check("coin_ovr",    ovr,    8'h00);
    step(1);
    check("coin_clr", status, 8'h00);
    clr   = 1'b0;
    cmask = 8'h00;

    // ch2 second enabled edge while status still set
    ren    = 8'h04;
    fen    = 8'h04;
    sig[2] = 1'b1;
    step(7);
    check("ovr_stat1", status, 8'h04);
    check("ovr_none",  ovr,    8'h00);
    sig[2] = 1'b0;
    step(6);
    check("ovr_fedge", fedge, 8'h04);
    step(1);
    check("ovr_set",   ovr,    OVR_EXP);
    check("ovr_stat2", status, 8'h04);
    clr   = 1'b1;
    cmask = 8'h04;
    step(1);
    check("ovr_clr",      ovr,    8'h00);
    check("ovr_stat_clr", status, 8'h00);
    clr   = 1'b0;
    cmask = 8'h00;

    // simultaneous rises on ch4..7
    ren = 8'hFF;
    fen = 8'h00;
    sig = 8'hF1;
    step(6);
    check("multi_redge", redge, 8'hF0);
    check("multi_level", level, 8'hF1);
    step(1);
    check("multi_status", status,  8'hF0);
    check("multi_irq",    8'(irq), 8'h01);

    // async reset mid-qualification
    sig = 8'hFF;
    step(3);
    #3 rst = 1'b1;
    #1;
    check("arst_level",  level,   8'h00);
    check("arst_redge",  redge,   8'h00);
    check("arst_status", status,  8'h00);
    check("arst_irq",    8'(irq), 8'h00);
    check("arst_ovr",    ovr,     8'h00);
    step(1);
    #3 rst = 1'b0;
    step(5);
    check("rel_level_early", level, 8'h00);
    check("rel_redge_early", redge, 8'h00);
    step(1);
    check("rel_level", level, 8'hFF);
    check("rel_redge", redge, 8'hFF);
    step(1);
    check("rel_status", status,  8'hFF);
    check("rel_irq",    8'(irq), 8'h01);
    check("rel_pulse",  redge,   8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/edge_detector_multi.md
EDGE_DETECTOR_MULTI -- requirements
Module: edge_detector_multi

Interface
REQ-001 Parameter CHANNELS, default 8: number of independent input channels, legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser depth per channel, legal range 2..4.
REQ-003 Parameter FILTER_DEPTH, default 4: consecutive differing samples needed to accept a level change, legal range 1..255.
REQ-004 Parameter RESET_VALUE, default 1'b0: reset level of the synchroniser and filtered level, replicated per channel.
REQ-005 Port CLK_I  input  1: single clock; all state SHALL be clocked on its rising edge.
REQ-006 Port RST_ASYNC_I  input  1: reset, asynchronous and active-high.
REQ-007 Port SIG_I  input  CHANNELS: monitored signals, asynchronous to CLK_I.
REQ-008 Port REDGE_EN_I  input  CHANNELS: per-channel enable for latching rising edges into status.
REQ-009 Port FEDGE_EN_I  input  CHANNELS: per-channel enable for latching falling edges into status.
REQ-010 Port CLR_I  input  1: status clear strobe, sampled on each rising edge of CLK_I.
REQ-011 Port CLR_MASK_I  input  CHANNELS: channels cleared when CLR_I=1; write-one-to-clear.
REQ-012 Port SIG_LEVEL_O  output  CHANNELS: filtered, debounced level per channel.
REQ-013 Port SIG_REDGE_O  output  CHANNELS: one-cycle pulse on a filtered 0->1 transition; independent of enables.
REQ-014 Port SIG_FEDGE_O  output  CHANNELS: one-cycle pulse on a filtered 1->0 transition; independent of enables.
REQ-015 Port EVT_STATUS_O  output  CHANNELS: sticky per-channel event flags.
REQ-016 Port EVT_OVR_O  output  CHANNELS: sticky per-channel overrun flags.
REQ-017 Port IRQ_O  output  1: OR of all EVT_STATUS_O bits, derived from registers only.

Function
REQ-018 Each channel SHALL pass SIG_I through a SYNC_STAGES-deep flop chain before any other use.
REQ-019 Per-channel counter, width clog2(FILTER_DEPTH+1):
 - synchronised sample equals SIG_LEVEL_O -> counter SHALL reset to 0;
 - sample differs -> counter SHALL increment.
REQ-020 SIG_LEVEL_O SHALL toggle, and the counter clear to 0, on the edge where the count reaches FILTER_DEPTH.
REQ-021 FILTER_DEPTH=1 SHALL toggle on the first differing synchronised sample.
REQ-022 Latency: SIG_I changes before edge k and holds -> SIG_LEVEL_O and the matching edge pulse SHALL update after edge k+SYNC_STAGES+FILTER_DEPTH-1.
REQ-023 Each edge pulse SHALL last exactly one clock cycle.
REQ-024 A glitch shorter than FILTER_DEPTH synchronised samples SHALL produce no level change and no pulse.
REQ-025 EVT_STATUS_O[i] SHALL set on (SIG_REDGE_O[i]&REDGE_EN_I[i]) | (SIG_FEDGE_O[i]&FEDGE_EN_I[i]).
REQ-026 EVT_STATUS_O[i] SHALL clear on CLR_I&CLR_MASK_I[i]; a set in the same cycle SHALL win over the clear.
REQ-027 Changing REDGE_EN_I or FEDGE_EN_I SHALL affect only future edges and SHALL NOT modify existing status.
REQ-028 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be captured.
REQ-029 IRQ_O SHALL assert the cycle after the first status bit sets and deassert the cycle after the last one clears.

Reset
REQ-030 While RST_ASYNC_I=1, the following SHALL be forced immediately, independent of CLK_I:
 - synchroniser flops and SIG_LEVEL_O to {CHANNELS{RESET_VALUE}};
 - counters to 0;
 - SIG_REDGE_O, SIG_FEDGE_O, EVT_STATUS_O, EVT_OVR_O and IRQ_O to 0.
REQ-031 Reset mid-filter SHALL discard the partial count.
REQ-032 After reset release, an input differing from RESET_VALUE SHALL requalify per REQ-022; no pulse SHALL be generated earlier.

Configuration
REQ-033 Macro EDGE_DET_OVERRUN_EN defined: EVT_OVR_O[i] SHALL set when an enabled edge occurs while EVT_STATUS_O[i]=1 and that bit is not being cleared in the same cycle.
REQ-034 With EDGE_DET_OVERRUN_EN defined, EVT_OVR_O[i] SHALL clear with the same CLR_I/CLR_MASK_I rule as status.
REQ-035 Macro EDGE_DET_OVERRUN_EN undefined: EVT_OVR_O SHALL be constant 0 and no overrun logic SHALL be synthesised.

Verification (defaults: CHANNELS=8, SYNC_STAGES=2, FILTER_DEPTH=4)
REQ-036 SIG_I[0] 0->1 before edge 10, held -> SIG_LEVEL_O[0]=1 and SIG_REDGE_O[0] one-cycle pulse after edge 15.
REQ-037 SIG_I[3] high for 3 cycles then low -> no change on SIG_LEVEL_O, SIG_REDGE_O or EVT_STATUS_O.
REQ-038 REDGE_EN_I=8'h01, rising edge on ch0 -> EVT_STATUS_O=8'h01 and IRQ_O=1 next cycle; CLR_I=1 with CLR_MASK_I=8'h01 -> status 0 and IRQ_O=0 next cycle.
REQ-039 Ch0 filtered rising edge coincides with CLR_I=1, CLR_MASK_I=8'h01 -> EVT_STATUS_O[0] remains 1 and EVT_OVR_O[0]=0.
REQ-040 Overrun build: second enabled ch2 edge with status already set -> EVT_OVR_O=8'h04; non-overrun build -> EVT_OVR_O=8'h00.
REQ-041 RST_ASYNC_I pulsed mid-qualification with SIG_I=8'hFF, RESET_VALUE=0 -> all outputs 0 immediately; SIG_LEVEL_O=8'hFF and all eight rising-edge pulses after edge 5 counted from the first edge after release.
